// File: rtl/usr_defs.sv
// Shared mode encodings for the universal shift register and its bit cells.
package usr_defs;

  localparam int USR_MODE_W = 2;

  localparam logic [USR_MODE_W-1:0] USR_HOLD = 2'b00;
  localparam logic [USR_MODE_W-1:0] USR_SHL  = 2'b01;
  localparam logic [USR_MODE_W-1:0] USR_SHR  = 2'b10;
  localparam logic [USR_MODE_W-1:0] USR_LOAD = 2'b11;

endpackage

// File: rtl/usr_bit_cell.sv
// One register bit: a 4:1 mux (hold / lower neighbour / upper neighbour / load)
// feeding a D flip-flop with asynchronous reset to a per-cell value.
module usr_bit_cell
  import usr_defs::*;
(
  input  logic                  clk,
  input  logic                  r,
  input  logic [USR_MODE_W-1:0] mode,
  input  logic                  from_lo,
  input  logic                  from_hi,
  input  logic                  d,
  input  logic                  rst_val,
  output logic                  q,
  output logic                  q1
);

  logic nxt;

  always_comb begin
    nxt = q;
    case (mode)
      USR_HOLD: nxt = q;
      USR_SHL:  nxt = from_lo;
      USR_SHR:  nxt = from_hi;
      USR_LOAD: nxt = d;
      default:  nxt = q;
    endcase
  end

  always_ff @(posedge clk or posedge r) begin
    if (r) begin
      q <= rst_val;
    end else begin
      q <= nxt;
    end
  end

  assign q1 = ~q;

endmodule

// File: rtl/univ_shift_reg.sv
// W-bit universal shift register: hold, shift left, shift right, parallel load.
// Define USR_ROTATE_EN to make the shift modes rotate instead of using sin_l/sin_r.
module univ_shift_reg
  import usr_defs::*;
#(
  parameter int             W         = 8,
  parameter logic [W-1:0]   RESET_VAL = '0
) (
  input  logic                  clk,
  input  logic                  r,
  input  logic [USR_MODE_W-1:0] mode,
  input  logic [W-1:0]          d,
  input  logic                  sin_l,
  input  logic                  sin_r,
  output logic [W-1:0]          q,
  output logic [W-1:0]          q1,
  output logic                  so_l,
  output logic                  so_r
);

  logic          end_lo;
  logic          end_hi;
  logic [W-1:0]  lo_in;
  logic [W-1:0]  hi_in;

`ifdef USR_ROTATE_EN
  // Serial inputs stay on the port list but are deliberately not used here.
  logic unused_sin;
  assign unused_sin = sin_l ^ sin_r;
  assign end_lo     = q[W-1];
  assign end_hi     = q[0];
`else
  assign end_lo = sin_l;
  assign end_hi = sin_r;
`endif

  // Shift left moves each bit up from its lower neighbour; shift right from its upper one.
  assign lo_in = {q[W-2:0], end_lo};
  assign hi_in = {end_hi, q[W-1:1]};

  for (genvar i = 0; i < W; i++) begin : g_cell
    usr_bit_cell u_cell (
      .clk     (clk),
      .r       (r),
      .mode    (mode),
      .from_lo (lo_in[i]),
      .from_hi (hi_in[i]),
      .d       (d[i]),
      .rst_val (RESET_VAL[i]),
      .q       (q[i]),
      .q1      (q1[i])
    );
  end

  assign so_l = q[W-1];
  assign so_r = q[0];

endmodule
